// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND copy controller: flash command bytes,
// page geometry and the flash-B page-program state encoding.
package nfc_pkg;

  localparam logic [7:0]  CMD_PROG   = 8'h80;
  localparam logic [7:0]  CMD_CONF   = 8'h10;
  localparam int unsigned PAGE_BYTES = 512;
  localparam int unsigned PAGE_W     = 9;
  localparam int unsigned CNT_W      = 9;

  typedef enum logic [3:0] {
    ST_C1_L, ST_C1_H,
    ST_A0_L, ST_A0_H,
    ST_A1_L, ST_A1_H,
    ST_A2_L, ST_A2_H,
    ST_LOAD,
    ST_D_L,  ST_D_H,
    ST_C2_L, ST_C2_H,
    ST_TWB,
    ST_BUSY,
    ST_FIN
  } nfc_state_e;

  function automatic logic we_low(input nfc_state_e s);
    return s inside {ST_C1_L, ST_A0_L, ST_A1_L, ST_A2_L, ST_D_L, ST_C2_L};
  endfunction

endpackage

// File: rtl/nfc_page_writer.sv
// Flash-B page-program engine: streams bytes from the read side into
// successive flash-B pages (80h, 3 address cycles, 512 data bytes, 10h, R/B wait).
module nfc_page_writer
  import nfc_pkg::*;
#(
  parameter int unsigned PAGES      = 512,
  parameter int unsigned TWB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [8:0]  page_idx,
  output logic        done,
  inout  wire  [7:0]  F_IO_B,
  output logic        F_CLE_B,
  output logic        F_ALE_B,
  output logic        F_REN_B,
  output logic        F_WEN_B,
  input  logic        F_RB_B
);

  localparam int unsigned         TW        = (TWB_CYCLES > 1) ? $clog2(TWB_CYCLES) : 1;
  localparam logic [TW-1:0]       TWB_LAST  = TW'(TWB_CYCLES - 1);
  localparam logic [PAGE_W-1:0]   PAGE_LAST = PAGE_W'(PAGES - 1);
  localparam logic [CNT_W-1:0]    BYTE_LAST = CNT_W'(PAGE_BYTES - 1);

  nfc_state_e        state_q, state_d;
  logic [PAGE_W-1:0] page_idx_q, page_idx_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]     twb_cnt_q, twb_cnt_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        io_q, io_d;
  logic              cle_q, cle_d;
  logic              ale_q, ale_d;
  logic              wen_q, wen_d;

  always_comb begin : next_state
    state_d    = state_q;
    page_idx_d = page_idx_q;
    byte_cnt_d = byte_cnt_q;
    twb_cnt_d  = twb_cnt_q;
    data_d     = data_q;
    case (state_q)
      ST_C1_L: state_d = ST_C1_H;
      ST_C1_H: state_d = ST_A0_L;
      ST_A0_L: state_d = ST_A0_H;
      ST_A0_H: state_d = ST_A1_L;
      ST_A1_L: state_d = ST_A1_H;
      ST_A1_H: state_d = ST_A2_L;
      ST_A2_L: state_d = ST_A2_H;
      ST_A2_H: state_d = ST_LOAD;
      ST_LOAD: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = ST_D_L;
        end
      end
      ST_D_L: state_d = ST_D_H;
      ST_D_H: begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d    = (byte_cnt_q == BYTE_LAST) ? ST_C2_L : ST_LOAD;
      end
      ST_C2_L: state_d = ST_C2_H;
      ST_C2_H: begin
        twb_cnt_d = '0;
        state_d   = ST_TWB;
      end
      ST_TWB: begin
        if (twb_cnt_q == TWB_LAST) state_d = ST_BUSY;
        else                       twb_cnt_d = twb_cnt_q + TW'(1);
      end
      ST_BUSY: begin
        if (F_RB_B) begin
          byte_cnt_d = '0;
          if (page_idx_q == PAGE_LAST) begin
            state_d = ST_FIN;
          end else begin
            page_idx_d = page_idx_q + PAGE_W'(1);
            state_d    = ST_C1_L;
          end
        end
      end
      ST_FIN:  state_d = ST_FIN;
      default: state_d = ST_C1_L;
    endcase
  end

  // Bus pins are a registered decode of the current state, so each pin change
  // trails its state by one clock and every _L/_H pair gives one clock of setup and hold.
  always_comb begin : bus_decode
    cle_d = 1'b0;
    ale_d = 1'b0;
    io_d  = '0;
    wen_d = ~we_low(state_q);
    case (state_q)
      ST_C1_L, ST_C1_H: begin
        cle_d = 1'b1;
        io_d  = CMD_PROG;
      end
      ST_A0_L, ST_A0_H: ale_d = 1'b1;
      ST_A1_L, ST_A1_H: begin
        ale_d = 1'b1;
        io_d  = page_idx_q[7:0];
      end
      ST_A2_L, ST_A2_H: begin
        ale_d = 1'b1;
        io_d  = {7'b0, page_idx_q[8]};
      end
      ST_LOAD:        io_d = io_q;
      ST_D_L, ST_D_H: io_d = data_q;
      ST_C2_L, ST_C2_H: begin
        cle_d = 1'b1;
        io_d  = CMD_CONF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_C1_L;
      page_idx_q <= '0;
      byte_cnt_q <= '0;
      twb_cnt_q  <= '0;
      data_q     <= '0;
      io_q       <= '0;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      wen_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      page_idx_q <= page_idx_d;
      byte_cnt_q <= byte_cnt_d;
      twb_cnt_q  <= twb_cnt_d;
      data_q     <= data_d;
      io_q       <= io_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      wen_q      <= wen_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign done     = (state_q == ST_FIN);
  assign page_idx = page_idx_q;
  assign F_IO_B   = io_q;
  assign F_CLE_B  = cle_q;
  assign F_ALE_B  = ale_q;
  assign F_WEN_B  = wen_q;
  assign F_REN_B  = 1'b1;

endmodule

// File: tb/tb_nfc_page_writer.sv
// Bench for nfc_page_writer: a flash-B bus logger plus R/B model, checked
// against the expected page-program command sequence and bus timing.
`timescale 1ns/1ps
module tb_nfc_page_writer;

  localparam int NPAGES = 4;
  localparam int TWB    = 4;
  localparam int PB     = 512;
  localparam int RECS   = PB + 5;
  localparam int LIMIT  = 15000;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, done;
  logic       cle, ale, ren, wen, rb;
  logic [7:0] in_data;
  logic [8:0] page_idx;
  wire  [7:0] io_b;

  nfc_page_writer #(.PAGES(NPAGES), .TWB_CYCLES(TWB)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .page_idx(page_idx), .done(done), .F_IO_B(io_b),
    .F_CLE_B(cle), .F_ALE_B(ale), .F_REN_B(ren), .F_WEN_B(wen), .F_RB_B(rb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [9:0] ev; } latch_t;
  typedef struct { bit hold; int busy; int exp_gap; } rb_vec_t;

  latch_t       log_q[$];
  rb_vec_t      rb_tab[NPAGES];
  byte unsigned rand_bytes[NPAGES*PB];

  int total = 0, bad = 0;
  bit src_on, src_rand, rdy_prev, wen_prev, done_seen;
  int src_idx, pg_cfg, rb_release, rst_cyc;
  int first_rdy, done_cyc, done_rises, done_drops, stall_bad, stall_n, idle_bad;
  int busy_len[NPAGES];
  bit hold_hi[NPAGES];
  int exp_gap[NPAGES];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of the environment: source handshake, flash-B logger and R/B model.
  task automatic tick();
    @(negedge clk);
    if (in_valid && rdy_prev && !rst) src_idx++;
    if (wen && !wen_prev) begin
      log_q.push_back('{cyc, {cle, ale, io_b}});
      if (cle && io_b == 8'h10 && !rst) begin
        if (!hold_hi[pg_cfg]) begin
          rb = 1'b0;
          rb_release = cyc + TWB + busy_len[pg_cfg];
        end
        if (pg_cfg < NPAGES - 1) pg_cfg++;
      end
    end
    wen_prev = wen;
    if (!rb && cyc == rb_release) rb = 1'b1;
    if (in_ready) begin
      stall_n++;
      if (!wen || (rdy_prev && (cle || ale))) stall_bad++;
    end
    if (done && in_ready) idle_bad++;
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      done_rises++;
    end
    if (!done && done_seen) done_drops++;
    if (in_ready && first_rdy < 0) first_rdy = cyc;
    rdy_prev = in_ready;
    in_valid = src_on && (!src_rand || $urandom_range(1) == 1);
    in_data  = src_rand ? rand_bytes[src_idx % (NPAGES*PB)] : 8'(src_idx);
  endtask

  task automatic reset_phase();
    rst = 1'b1; src_on = 1'b0; in_valid = 1'b0; rb = 1'b1; rb_release = -1;
    repeat (3) tick();
  endtask

  task automatic release_run(input bit rnd);
    log_q.delete();
    src_idx = 0; pg_cfg = 0; first_rdy = -1; done_seen = 1'b0; done_cyc = -1;
    done_rises = 0; done_drops = 0; stall_bad = 0; stall_n = 0; idle_bad = 0;
    src_rand = rnd; src_on = 1'b1; rst = 1'b0; rst_cyc = cyc;
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (!done && n < LIMIT) begin
      tick();
      n++;
    end
    chk({tag, "_done_timeout"}, int'(done), 1);
  endtask

  function automatic logic [9:0] exp_rec(input int p, input int k);
    logic [8:0] pa;
    int idx;
    pa = 9'(p);
    if (k == 0)        return {2'b10, 8'h80};
    if (k == 1)        return {2'b01, 8'h00};
    if (k == 2)        return {2'b01, pa[7:0]};
    if (k == 3)        return {2'b01, 7'b0, pa[8]};
    if (k == RECS - 1) return {2'b10, 8'h10};
    idx = p * PB + k - 4;
    return {2'b00, src_rand ? rand_bytes[idx] : 8'(idx)};
  endfunction

  function automatic int exp_step(input int k);
    if (k <= 3 || k == RECS - 1) return 2;
    return 3;
  endfunction

  task automatic verify_run(input string tag, input bit exact);
    chk({tag, "_first_80h_cyc"}, (log_q.size() > 0) ? log_q[0].cyc - rst_cyc : -1, 2);
    chk({tag, "_first_ready_cyc"}, first_rdy - rst_cyc, 8);
    repeat (30) tick();
    chk({tag, "_log_size"}, log_q.size(), NPAGES * RECS);
    chk({tag, "_bytes_taken"}, src_idx, NPAGES * PB);
    chk({tag, "_page_idx_end"}, int'(page_idx), NPAGES - 1);
    chk({tag, "_done_rises"}, done_rises, 1);
    chk({tag, "_done_drops"}, done_drops, 0);
    chk({tag, "_ready_in_fin"}, idle_bad, 0);
    chk({tag, "_stall_bus"}, stall_bad, 0);
    if (log_q.size() == NPAGES * RECS) begin
      for (int p = 0; p < NPAGES; p++) begin
        int fk = -1;
        logic [9:0] got = '0, want = '0;
        int gk = -1, ggot = 0, gwant = 0;
        for (int k = 0; k < RECS; k++) begin
          if (log_q[p*RECS+k].ev !== exp_rec(p, k) && fk < 0) begin
            fk = k; got = log_q[p*RECS+k].ev; want = exp_rec(p, k);
          end
          if (k > 0 && (exact || k <= 3 || k == RECS - 1) && gk < 0 &&
              log_q[p*RECS+k].cyc - log_q[p*RECS+k-1].cyc != exp_step(k)) begin
            gk = k; ggot = log_q[p*RECS+k].cyc - log_q[p*RECS+k-1].cyc; gwant = exp_step(k);
          end
        end
        total++;
        if (fk >= 0) begin
          bad++;
          $display("FAIL %s_page%0d_bus rec %0d: got {cle,ale,io}=%h expected %h", tag, p, fk, got, want);
        end
        total++;
        if (gk >= 0) begin
          bad++;
          $display("FAIL %s_page%0d_timing rec %0d: got gap %0d expected %0d", tag, p, gk, ggot, gwant);
        end
        if (p < NPAGES - 1)
          chk($sformatf("%s_page%0d_rb_gap", tag, p),
              log_q[(p+1)*RECS].cyc - log_q[p*RECS+RECS-1].cyc, exp_gap[p]);
        else
          chk($sformatf("%s_done_gap", tag), done_cyc - log_q[p*RECS+RECS-1].cyc, exp_gap[p]);
      end
    end
  endtask

  initial begin
    rb_tab[0] = '{hold: 1'b0, busy: 200, exp_gap: 207};
    rb_tab[1] = '{hold: 1'b1, busy: 0,   exp_gap: 7};
    rb_tab[2] = '{hold: 1'b0, busy: 1,   exp_gap: 8};
    rb_tab[3] = '{hold: 1'b0, busy: 0,   exp_gap: 5};
    for (int i = 0; i < NPAGES * PB; i++) rand_bytes[i] = 8'($urandom);
    wen_prev = 1'b1; rdy_prev = 1'b0; in_data = '0;

    // Run A: incrementing stream, valid held high, R/B behaviour from the table.
    for (int p = 0; p < NPAGES; p++) begin
      busy_len[p] = rb_tab[p].busy;
      hold_hi[p]  = rb_tab[p].hold;
      exp_gap[p]  = rb_tab[p].exp_gap;
    end
    reset_phase();
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_page_idx", int'(page_idx), 0);
    chk("reset_cle", int'(cle), 0);
    chk("reset_ale", int'(ale), 0);
    chk("reset_wen", int'(wen), 1);
    chk("reset_ren", int'(ren), 1);
    chk("reset_io", int'(io_b), 0);
    release_run(1'b0);
    run_to_done("A");
    verify_run("A", 1'b1);

    // Run B: random byte values, 50% valid duty, random busy times.
    for (int p = 0; p < NPAGES; p++) begin
      busy_len[p] = $urandom_range(30);
      hold_hi[p]  = 1'b0;
      exp_gap[p]  = (p < NPAGES - 1) ? TWB + 3 + busy_len[p] : TWB + 1 + busy_len[p];
    end
    reset_phase();
    release_run(1'b1);
    run_to_done("B");
    verify_run("B", 1'b0);
    chk("B_stalls_seen", int'(stall_n > NPAGES * PB), 1);

    // Run C: reset during page 3, then the full sequence restarts from page 0.
    for (int p = 0; p < NPAGES; p++) begin
      busy_len[p] = 0;
      hold_hi[p]  = 1'b0;
      exp_gap[p]  = (p < NPAGES - 1) ? TWB + 3 : TWB + 1;
    end
    reset_phase();
    release_run(1'b0);
    begin
      int n = 0;
      while (src_idx < 3 * PB + 100 && n < LIMIT) begin
        tick();
        n++;
      end
    end
    chk("C_reach_byte100", src_idx, 3 * PB + 100);
    chk("C_page_before_rst", int'(page_idx), 3);
    reset_phase();
    chk("C_rst_done", int'(done), 0);
    chk("C_rst_page_idx", int'(page_idx), 0);
    chk("C_rst_in_ready", int'(in_ready), 0);
    chk("C_rst_wen", int'(wen), 1);
    release_run(1'b0);
    run_to_done("C");
    verify_run("C", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
